// File: rtl/smi_rx_arbiter.sv
// smi_rx_arbiter: grants the two radio RX FIFOs to the SMI RX port
// in bursts, separated by a guard gap; fixed or round-robin.
module smi_rx_arbiter #(
  parameter int  BURST_WORDS  = 64,
  parameter int  GUARD_CYCLES = 4,
  localparam int CW = $clog2(BURST_WORDS + 1)
) (
  input  logic          i_sys_clk,
  input  logic          i_rst_b,
  input  logic          i_enable,
  input  logic [1:0]    i_mode,
  input  logic          i_ch0_empty,
  input  logic          i_ch1_empty,
  input  logic [31:0]   i_ch0_data,
  input  logic [31:0]   i_ch1_data,
  output logic          o_ch0_pull,
  output logic          o_ch1_pull,
  input  logic          i_pull,
  output logic [31:0]   o_data,
  output logic          o_empty,
  output logic          o_active_ch,
  output logic          o_busy,
  output logic [CW-1:0] o_burst_cnt,
  output logic          o_underrun
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(BURST_WORDS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_STREAM,
    S_GUARD
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          busy_q;
  logic          uf_q;

  logic streaming;
  logic sel_empty;
  logic oth_empty;
  logic accept;
  logic pick;
  logic pick_ch;

  assign streaming = (state_q == S_STREAM);
  assign sel_empty = sel_q ? i_ch1_empty : i_ch0_empty;
  assign oth_empty = sel_q ? i_ch0_empty : i_ch1_empty;

  assign o_data  = sel_q ? i_ch1_data : i_ch0_data;
  assign o_empty = streaming ? sel_empty : 1'b1;

  assign o_ch0_pull = streaming & i_pull
                    & ~sel_q & ~i_ch0_empty;
  assign o_ch1_pull = streaming & i_pull
                    & sel_q & ~i_ch1_empty;
  assign accept = o_ch0_pull | o_ch1_pull;

  // Round-robin prefers the channel not served last time.
  always_comb begin
    pick    = 1'b0;
    pick_ch = sel_q;
    if (i_mode[1]) begin
      if (!oth_empty) begin
        pick    = 1'b1;
        pick_ch = ~sel_q;
      end else if (!sel_empty) begin
        pick    = 1'b1;
        pick_ch = sel_q;
      end
    end else begin
      pick_ch = i_mode[0];
      pick    = i_mode[0] ? ~i_ch1_empty
                          : ~i_ch0_empty;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_SELECT;
      end
      S_SELECT: begin
        rr_d = i_mode[1];
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (pick) begin
          sel_d   = pick_ch;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if ((accept && cnt_q == LAST)
            || !i_enable
            || (rr_q && sel_empty && !oth_empty)) begin
          state_d = S_GUARD;
          gcnt_d  = '0;
        end
      end
      S_GUARD: begin
        if (gcnt_q == GLAST) state_d = S_SELECT;
        else gcnt_d = gcnt_q + GW'(1);
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= (state_d == S_STREAM);
      uf_q    <= i_pull & o_empty;
    end
  end

  assign o_active_ch = sel_q;
  assign o_busy      = busy_q;
  assign o_burst_cnt = cnt_q;
  assign o_underrun  = uf_q;

endmodule

// File: tb/tb_smi_rx_arbiter.sv
// tb_smi_rx_arbiter: randomized bench with queue-based upstream FIFOs
// and a grant-sequence model for smi_rx_arbiter.
module tb_smi_rx_arbiter;

  localparam int B  = 4;
  localparam int G  = 2;
  localparam int CW = $clog2(B + 1);

  logic          clk = 1'b0;
  logic          rst_b;
  logic          en;
  logic          pull;
  logic [1:0]    mode;
  logic          e0, e1;
  logic [31:0]   d0, d1;
  logic          p0, p1;
  logic [31:0]   od;
  logic          oe, ach, busy, uf;
  logic [CW-1:0] bcnt;

  always #5 clk = ~clk;

  smi_rx_arbiter #(
    .BURST_WORDS (B),
    .GUARD_CYCLES(G)
  ) dut (
    .i_sys_clk  (clk),
    .i_rst_b    (rst_b),
    .i_enable   (en),
    .i_mode     (mode),
    .i_ch0_empty(e0),
    .i_ch1_empty(e1),
    .i_ch0_data (d0),
    .i_ch1_data (d1),
    .o_ch0_pull (p0),
    .o_ch1_pull (p1),
    .i_pull     (pull),
    .o_data     (od),
    .o_empty    (oe),
    .o_active_ch(ach),
    .o_busy     (busy),
    .o_burst_cnt(bcnt),
    .o_underrun (uf)
  );

  typedef struct {
    logic        pull, e, p0, p1;
    logic        uf, busy, ach, hit;
    logic [31:0] d, exp;
    int          cnt;
  } rec_t;

  typedef struct {
    bit ch;
    int len;
  } gr_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  rec_t        tr[$];
  gr_t         pg[$];
  int          gs[$], ge[$], gl[$];
  logic        gc[$];
  bit          gt[$];

  task automatic refresh();
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    d0 = e0 ? 32'h0 : q0[0];
    d1 = e1 ? 32'h0 : q1[0];
  endtask

  // One clock cycle: sample at negedge, let upstream pops land after posedge.
  task automatic step();
    rec_t r;
    @(negedge clk);
    r.pull = pull;  r.e = oe;  r.p0 = p0;  r.p1 = p1;
    r.uf = uf;  r.busy = busy;  r.ach = ach;  r.d = od;
    r.cnt = int'(bcnt);  r.exp = '0;  r.hit = 1'b0;
    if (p0 && !p1 && q0.size() > 0) begin
      r.exp = q0.pop_front();  r.hit = 1'b1;
    end else if (p1 && !p0 && q1.size() > 0) begin
      r.exp = q1.pop_front();  r.hit = 1'b1;
    end
    tr.push_back(r);
    @(posedge clk); #1;
    refresh();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;  en = 1'b0;  pull = 1'b0;  mode = 2'b00;
    q0.delete();  q1.delete();  refresh();
    @(posedge clk); #1;
    rst_b = 1'b1;
    tr.delete();
  endtask

  // Expected grant list from queue depths alone.
  function automatic void predict(int n0, int n1, logic [1:0] m);
    int n[2];
    bit last, c, ok;
    int take;
    n[0] = n0;  n[1] = n1;  last = 1'b0;  c = 1'b0;
    pg.delete();
    for (int k = 0; k < 64; k++) begin
      ok = 1'b1;
      if (m[1]) begin
        if (n[~last] > 0) c = ~last;
        else if (n[last] > 0) c = last;
        else ok = 1'b0;
      end else begin
        c = m[0];
        ok = (n[c] > 0);
      end
      if (!ok) break;
      take = (n[c] < B) ? n[c] : B;
      pg.push_back('{ch: c, len: take});
      n[c] -= take;
      last = c;
    end
  endfunction

  task automatic extract();
    bit inr;
    inr = 1'b0;
    gs.delete(); ge.delete(); gl.delete(); gc.delete(); gt.delete();
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].busy === 1'b1 && !inr) begin
        inr = 1'b1;
        gs.push_back(i);  gc.push_back(tr[i].ach);  gl.push_back(0);
      end
      if (tr[i].busy === 1'b1 && (tr[i].p0 || tr[i].p1))
        gl[gl.size()-1] = gl[gl.size()-1] + 1;
      if (tr[i].busy !== 1'b1 && inr) begin
        inr = 1'b0;
        ge.push_back(i - 1);  gt.push_back(1'b1);
      end
    end
    if (inr) begin
      ge.push_back(tr.size() - 1);  gt.push_back(1'b0);
    end
  endtask

  function automatic int grant_errs();
    int n = 0;
    if (gs.size() != pg.size()) return 1000;
    foreach (pg[i])
      if (gc[i] !== pg[i].ch || gl[i] != pg[i].len) n++;
    return n;
  endfunction

  function automatic int gap_errs();
    int n = 0;
    for (int i = 0; i + 1 < gs.size(); i++) begin
      if (gs[i+1] - ge[i] - 1 != G + 1) n++;
      for (int k = ge[i] + 1; k < gs[i+1]; k++)
        if (tr[k].e !== 1'b1) n++;
    end
    return n;
  endfunction

  function automatic int data_errs();
    int n = 0;
    foreach (tr[i])
      if ((tr[i].p0 || tr[i].p1)
          && (!tr[i].hit || tr[i].d !== tr[i].exp)) n++;
    return n;
  endfunction

  function automatic int cnt_errs();
    int n = 0;
    foreach (ge[i]) begin
      if (gt[i] && tr[ge[i]+1].cnt != gl[i]) n++;
      if (gt[i] && ge[i] + 2 < tr.size()
          && tr[ge[i]+2].cnt != gl[i]) n++;
    end
    return n;
  endfunction

  function automatic int uf_errs();
    int n = 0;
    for (int k = 1; k < tr.size(); k++)
      if (tr[k].uf !== (tr[k-1].pull & tr[k-1].e)) n++;
    return n;
  endfunction

  task automatic run_scn(int n0, int n1, logic [1:0] m,
                         int dens, int ncyc);
    do_reset();
    mode = m;
    for (int i = 0; i < n0; i++) q0.push_back($urandom());
    for (int i = 0; i < n1; i++) q1.push_back($urandom());
    refresh();
    en = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      pull = (int'($urandom_range(99)) < dens);
      step();
    end
    pull = 1'b0;
    extract();
    predict(n0, n1, m);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;  en = 1'b1;  pull = 1'b1;  mode = 2'b10;
    q0.delete();  q1.delete();
    q0.push_back(32'h1234_5678);  q1.push_back(32'h9abc_def0);
    refresh();
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (p0 !== 1'b0) begin bad++;
      $display("FAIL rst_p0 got=%b want=0", p0); end
    total++; if (p1 !== 1'b0) begin bad++;
      $display("FAIL rst_p1 got=%b want=0", p1); end
    total++; if (oe !== 1'b1) begin bad++;
      $display("FAIL rst_empty got=%b want=1", oe); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (ach !== 1'b0) begin bad++;
      $display("FAIL rst_ach got=%b want=0", ach); end
    total++; if (bcnt !== '0) begin bad++;
      $display("FAIL rst_cnt got=%0d want=0", bcnt); end
    total++; if (uf !== 1'b0) begin bad++;
      $display("FAIL rst_uf got=%b want=0", uf); end
    en = 1'b0;  pull = 1'b0;  rst_b = 1'b1;
    tr.delete();
    for (int i = 0; i < 3; i++) step();
    total++; if (tr[2].e !== 1'b1 || tr[2].busy !== 1'b0) begin bad++;
      $display("FAIL idle_hold got=%b/%b want=1/0",
               tr[2].e, tr[2].busy); end
  endtask

  task automatic test_fixed_ch0();
    int n, np1;
    run_scn(10, 3, 2'b00, 100, 30);
    n = grant_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL fix_grants got=%0d want=%0d errs=%0d",
               gs.size(), pg.size(), n); end
    n = gap_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL fix_gap errs=%0d want=0", n); end
    n = data_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL fix_data errs=%0d want=0", n); end
    n = cnt_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL fix_cnt errs=%0d want=0", n); end
    n = (gs.size() > 0) ? gs[0] : -1;
    total++; if (n !== 2) begin bad++;
      $display("FAIL fix_latency got=%0d want=2", n); end
    np1 = 0;
    foreach (tr[i]) if (tr[i].p1 !== 1'b0) np1++;
    total++; if (np1 !== 0 || q1.size() != 3) begin bad++;
      $display("FAIL fix_ch1_idle got=%0d/%0d want=0/3",
               np1, q1.size()); end
  endtask

  task automatic test_rr_alternate();
    int n;
    run_scn(12, 12, 2'b10, 60, 150);
    n = grant_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL rr_grants got=%0d want=%0d errs=%0d",
               gs.size(), pg.size(), n); end
    n = gap_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL rr_gap errs=%0d want=0", n); end
    n = cnt_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL rr_cnt errs=%0d want=0", n); end
    n = data_errs() + uf_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL rr_data_uf errs=%0d want=0", n); end
  endtask

  task automatic test_early_release();
    int n;
    run_scn(2, 6, 2'b11, 70, 100);
    n = grant_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL early_grants got=%0d want=%0d errs=%0d",
               gs.size(), pg.size(), n); end
    n = (ge.size() > 1) ? tr[ge[1]+1].cnt : -1;
    total++; if (n !== 2) begin bad++;
      $display("FAIL early_cnt got=%0d want=2", n); end
    n = gap_errs() + data_errs();
    total++; if (n !== 0) begin bad++;
      $display("FAIL early_gap_data errs=%0d want=0", n); end
  endtask

  task automatic test_underrun();
    logic [15:0] pat;
    int nuf, np;
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back($urandom());
    refresh();
    en = 1'b1;
    pat = 16'h0ABC;
    for (int i = 0; i < 16; i++) begin
      pull = pat[i];
      step();
    end
    pull = 1'b0;
    nuf = 0;  np = 0;
    foreach (tr[i]) begin
      if (tr[i].uf === 1'b1) nuf++;
      if (tr[i].p0 || tr[i].p1) np++;
    end
    total++; if (tr[8].uf !== 1'b1) begin bad++;
      $display("FAIL uf_guard got=%b want=1", tr[8].uf); end
    total++; if (tr[12].uf !== 1'b1) begin bad++;
      $display("FAIL uf_empty got=%b want=1", tr[12].uf); end
    total++; if (nuf !== 2) begin bad++;
      $display("FAIL uf_count got=%0d want=2", nuf); end
    total++; if (np !== 5 || tr[7].p0 !== 1'b0
                 || tr[11].p0 !== 1'b0) begin bad++;
      $display("FAIL uf_pulls got=%0d want=5", np); end
    total++; if (tr[7].cnt !== 4 || tr[10].cnt !== 1) begin bad++;
      $display("FAIL uf_cnt got=%0d/%0d want=4/1",
               tr[7].cnt, tr[10].cnt); end
    total++; if (uf_errs() !== 0) begin bad++;
      $display("FAIL uf_rule errs=%0d want=0", uf_errs()); end
  endtask

  task automatic test_disable_mid();
    int nmid, first;
    do_reset();
    for (int i = 0; i < 8; i++) q0.push_back($urandom());
    refresh();
    en = 1'b1;  pull = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) en = 1'b0;
      if (i == 12) en = 1'b1;
      step();
    end
    pull = 1'b0;
    nmid = 0;  first = -1;
    for (int i = 4; i < 20; i++) begin
      if (i < 14 && (tr[i].p0 || tr[i].p1)) nmid++;
      if (first < 0 && tr[i].p0 === 1'b1) first = i;
    end
    total++; if (tr[3].p0 !== 1'b1) begin bad++;
      $display("FAIL dis_same_cycle got=%b want=1", tr[3].p0); end
    total++; if (tr[4].busy !== 1'b0 || tr[4].cnt !== 2) begin bad++;
      $display("FAIL dis_guard got=%b/%0d want=0/2",
               tr[4].busy, tr[4].cnt); end
    total++; if (nmid !== 0) begin bad++;
      $display("FAIL dis_no_pull got=%0d want=0", nmid); end
    total++; if (first !== 14) begin bad++;
      $display("FAIL dis_reenable got=%0d want=14", first); end
    total++; if (data_errs() !== 0) begin bad++;
      $display("FAIL dis_data errs=%0d want=0", data_errs()); end
  endtask

  task automatic test_async_reset();
    int first;
    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 6; i++) q1.push_back($urandom());
    refresh();
    en = 1'b1;  pull = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #2;
    total++; if (p1 !== 1'b1 || ach !== 1'b1) begin bad++;
      $display("FAIL ar_pre got=%b/%b want=1/1", p1, ach); end
    rst_b = 1'b0;
    #1;
    total++; if (p1 !== 1'b0 || oe !== 1'b1) begin bad++;
      $display("FAIL ar_drop got=%b/%b want=0/1", p1, oe); end
    total++; if (ach !== 1'b0 || busy !== 1'b0 || bcnt !== '0) begin
      bad++;
      $display("FAIL ar_regs got=%b/%b/%0d want=0/0/0",
               ach, busy, bcnt); end
    @(posedge clk); #1;
    total++; if (p1 !== 1'b0) begin bad++;
      $display("FAIL ar_held got=%b want=0", p1); end
    rst_b = 1'b1;
    tr.delete();
    for (int i = 0; i < 6; i++) step();
    pull = 1'b0;
    extract();
    first = (gs.size() > 0) ? gs[0] : -1;
    total++; if (first !== 2 || tr[2].p1 !== 1'b1) begin bad++;
      $display("FAIL ar_restart got=%0d want=2", first); end
    total++; if (data_errs() !== 0) begin bad++;
      $display("FAIL ar_data errs=%0d want=0", data_errs()); end
  endtask

  task automatic test_random();
    int n0, n1, dens, n;
    logic [1:0] m;
    for (int it = 0; it < 6; it++) begin
      n0   = $urandom_range(9);
      n1   = $urandom_range(9);
      m    = 2'($urandom_range(3));
      dens = $urandom_range(100, 30);
      run_scn(n0, n1, m, dens, 160);
      n = grant_errs();
      total++; if (n !== 0) begin bad++;
        $display("FAIL rnd%0d_grants got=%0d want=%0d errs=%0d",
                 it, gs.size(), pg.size(), n); end
      n = gap_errs();
      total++; if (n !== 0) begin bad++;
        $display("FAIL rnd%0d_gap errs=%0d want=0", it, n); end
      n = data_errs();
      total++; if (n !== 0) begin bad++;
        $display("FAIL rnd%0d_data errs=%0d want=0", it, n); end
      n = cnt_errs();
      total++; if (n !== 0) begin bad++;
        $display("FAIL rnd%0d_cnt errs=%0d want=0", it, n); end
      n = uf_errs();
      total++; if (n !== 0) begin bad++;
        $display("FAIL rnd%0d_uf errs=%0d want=0", it, n); end
    end
  endtask

  initial begin
    rst_b = 1'b0;  en = 1'b0;  pull = 1'b0;  mode = 2'b00;
    refresh();
    test_reset();
    test_fixed_ch0();
    test_rr_alternate();
    test_early_release();
    test_underrun();
    test_disable_mid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smi_rx_arbiter.md
# smi_rx_arbiter

Schedules the two per-radio RX sample FIFOs (channel 0 = sub-GHz, channel 1 = 2.4 GHz) onto the single 32-bit RX FIFO interface consumed by the SMI controller. Each grant is a burst of up to BURST_WORDS words from one channel, followed by a fixed guard gap. The block supports fixed-channel and round-robin modes. It sits between the two modem RX FIFOs and the SMI controller's RX pull/data/empty ports, and exposes status to the IOC register file.

## Interface
- BURST_WORDS, 64: maximum words per grant; ≥1.
- GUARD_CYCLES, 4: idle cycles between grants; ≥1.
- i_sys_clk  in  1  system clock
- i_rst_b  in  1  reset; asynchronous, active-low
- i_enable  in  1  arbitration enable
- i_mode  in  2  00 = ch0 only, 01 = ch1 only, 10 = round-robin, 11 = treated as 10
- i_ch0_empty / i_ch1_empty  in  1  upstream FIFO empty flags
- i_ch0_data / i_ch1_data  in  32  upstream FIFO head words
- o_ch0_pull / o_ch1_pull  out  1  upstream pull strobes
- i_pull  in  1  downstream pull (one word per cycle high)
- o_data  out  32  downstream word
- o_empty  out  1  downstream empty
- o_active_ch  out  1  channel of current or last grant
- o_busy  out  1  high in STREAM
- o_burst_cnt  out  $clog2(BURST_WORDS+1)  words accepted in current grant
- o_underrun  out  1  one-cycle pulse when i_pull arrives while o_empty=1

## Operation
- States are IDLE, SELECT, STREAM and GUARD. Reset enters IDLE.
- **IDLE**
  - o_empty=1.
  - If i_enable=1, go to SELECT.
- **SELECT**
  - o_empty=1. i_mode is sampled only here.
  - If i_enable=0, go to IDLE.
  - Fixed mode: pick the mode's channel once it is non-empty; otherwise stay.
  - Round-robin: pick the channel opposite o_active_ch if it is non-empty, else the same channel if it is non-empty; otherwise stay.
  - On pick: o_active_ch←channel, o_burst_cnt←0, go to STREAM.
- **STREAM**
  - o_data = selected channel's data (combinational mux).
  - o_empty = selected channel's empty flag.
  - o_chX_pull = i_pull & (sel==X) & !chX_empty. The unselected pull is always 0.
  - Each accepted pull increments o_burst_cnt.
  - Exit to GUARD on the cycle after any of these:
    - the accepted pull that brings o_burst_cnt to BURST_WORDS;
    - i_enable=0;
    - round-robin only: selected channel empty while the other channel is non-empty.
- **GUARD**
  - o_empty=1, no pulls.
  - Counter runs GUARD_CYCLES cycles, then goes to SELECT.
  - o_burst_cnt holds its final value until the next pick.
- **Underrun:** a pull with o_empty=1, in any state, sets o_underrun for one cycle. It never pulls upstream.
- **Data:** words pass through unmodified; the sync bits are not inspected.

## Timing
- **Reset values:** all pulls 0, o_empty=1, o_busy=0, o_active_ch=0, o_burst_cnt=0, o_underrun=0, state IDLE, guard counter 0.
- **Registered vs combinational:**
  - Registered: state, o_active_ch, o_burst_cnt, o_busy, o_underrun.
  - Combinational from registered select: o_data, o_empty, pulls.
- **Start-up latency:** i_enable sampled high at edge n gives SELECT after n. With the target non-empty, STREAM follows after n+1, so o_empty is low in cycle n+2.
- **Grant-to-grant gap:** last accepted pull at edge m; GUARD occupies cycles m+1 … m+GUARD_CYCLES. SELECT is in cycle m+GUARD_CYCLES+1 and the next STREAM in m+GUARD_CYCLES+2.
- **Simultaneous events:**
  - A pull coinciding with the BURST_WORDS boundary is accepted.
  - A pull in the same cycle as i_enable falling is accepted if the channel is non-empty.
- **Round-robin with only one channel active:** that channel is re-granted after each guard gap.
- **Mid-operation reset:** reset asserted mid-burst returns all outputs to reset values immediately (asynchronous); no pull is issued while i_rst_b=0.

## Test plan
- **Fixed ch0, BURST_WORDS=4, GUARD_CYCLES=2:** mode=00, ch0 holding 10 words, i_pull continuous -> ch0 pulls occur in bursts of 4,4,2. o_empty is high for exactly 3 cycles between bursts (GUARD plus SELECT). o_ch1_pull stays 0.
- **Round-robin alternation:** both channels full, mode=10 -> grants alternate ch1, ch0, ch1, … (first grant ch1 since o_active_ch resets to 0). o_burst_cnt reads 4 at each GUARD entry.
- **Early release:** mode=10, ch0 granted with 2 words, ch1 non-empty -> after 2 pulls ch0 is empty, GUARD follows, then ch1 is granted with o_burst_cnt=2 captured.
- **Underrun:** i_pull pulsed during GUARD and with the selected channel empty -> o_underrun=1 for 1 cycle each time, with no upstream pulls.
- **Disable mid-burst:** i_enable dropped after 1 of 4 words -> the same-cycle pull is accepted, then GUARD, then IDLE. No further pulls occur until re-enable.
- **Async reset mid-STREAM:** i_rst_b low between clock edges -> pulls drop at once, o_empty=1, o_active_ch=0. After release with i_enable=1, the first grant starts 2 cycles later.
